fp_mult_param: RTL

- Parametrised, iterative (shift-add) IEEE-754-style floating-point multiplier. It is the successor of the fixed 32-bit multiplier.
- Exponent and mantissa widths are generic. The same RTL therefore serves binary16, binary32 and custom formats.
- It keeps the start/done handshake and the nan/infinit/overflow/underflow flag set, and adds a busy indication.
- Sits in the datapath as a shared, low-area multiply unit driven by a controller or testbench.

---
 rtl/fp_mult_pkg.sv | 37 +++
 rtl/fp_mult_shift_add.sv | 51 +++++
 rtl/fp_mult_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and operand classification for the parametrised FP multiplier.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        ROUND,
        DONE
    } fp_state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    // Denormals classify as ZERO; they are flushed by the datapath.
    function automatic fp_class_t fp_classify(input logic [31:0] exp,
                                              input logic [63:0] man,
                                              input int unsigned exp_w);
        logic [31:0] exp_max;
        fp_class_t   cls;
        exp_max = (32'd1 << exp_w) - 32'd1;
        if (exp == 32'd0) begin
            cls = ZERO;
        end else if (exp == exp_max) begin
            cls = (man == 64'd0) ? INF : NAN;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_mult_shift_add.sv
// Iterative N x N unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module fp_mult_shift_add #(
    parameter int unsigned N = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           done_c
);

    localparam int unsigned CNT_W = $clog2(N);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   mcand;
    logic [N-1:0]     mplier;

    // High during the cycle whose closing edge folds in the last multiplier bit.
    assign done_c = running && (cnt == CNT_W'(N - 1));

    // The start edge already consumes bit 0, so the counter indexes the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
        end else if (start && !running) begin
            running <= 1'b1;
            cnt     <= CNT_W'(1);
            mcand   <= {{(N-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            prod    <= b[0] ? {{N{1'b0}}, a} : '0;
        end else if (running) begin
            if (mplier[0]) begin
                prod <= prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done_c) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_mult_param.sv
// Parametrised iterative IEEE-754-style multiplier with start/done handshake and busy.
// Build option: define FP_MULT_RNE_EN for round-to-nearest-even, otherwise truncation.
module fp_mult_param
    import fp_mult_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [EXP_W+MAN_W:0]   a_i,
    input  logic [EXP_W+MAN_W:0]   b_i,
    output logic [EXP_W+MAN_W:0]   product_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   nan_o,
    output logic                   infinit_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam int unsigned N       = MAN_W + 1;
    localparam int unsigned EW2     = EXP_W + 2;

    localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW2-1:0] BIAS_S   = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EXP_TOP  = EW2'(EXP_MAX);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;

`ifdef FP_MULT_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    fp_state_t state, state_next;

    logic [W-1:0]          a_r, b_r, res_r;
    logic                  sign_r;
    logic signed [EW2-1:0] exp_sum_r;
    logic [N-1:0]          mant_r;
    logic                  g_r, r_r, s_r;
    logic                  nan_r, inf_r, ovf_r, unf_r;

    logic                  mul_start_c, mul_done_c;
    logic [2*N-1:0]        mul_prod;

    logic [EXP_W-1:0]      ea_c, eb_c;
    logic [MAN_W-1:0]      ma_c, mb_c;
    fp_class_t             ca_c, cb_c;
    logic                  sign_c, special_c, nan_case_c, inf_case_c;

    logic [2*N-1:0]        norm_c;
    logic                  round_inc_c;
    logic [N:0]            rnd_sum_c;
    logic [MAN_W-1:0]      frac_c;
    logic signed [EW2-1:0] exp_fin_c;

    // Operand fields and classification from the captured operands.
    assign ea_c   = a_r[W-2 -: EXP_W];
    assign eb_c   = b_r[W-2 -: EXP_W];
    assign ma_c   = a_r[MAN_W-1:0];
    assign mb_c   = b_r[MAN_W-1:0];
    assign sign_c = a_r[W-1] ^ b_r[W-1];
    assign ca_c   = fp_classify(32'(ea_c), 64'(ma_c), EXP_W);
    assign cb_c   = fp_classify(32'(eb_c), 64'(mb_c), EXP_W);

    assign special_c  = (ca_c != NORMAL) || (cb_c != NORMAL);
    assign nan_case_c = (ca_c == NAN) || (cb_c == NAN) ||
                        ((ca_c == INF) && (cb_c == ZERO)) ||
                        ((ca_c == ZERO) && (cb_c == INF));
    assign inf_case_c = (ca_c == INF) || (cb_c == INF);

    // Product is in [1,4): align the leading one to the top bit.
    assign norm_c = mul_prod[2*N-1] ? mul_prod : (mul_prod << 1);

    // A rounding carry only happens from all-ones, so the fraction is zero either way.
    assign round_inc_c = RNE_EN & g_r & (r_r | s_r | mant_r[0]);
    assign rnd_sum_c   = {1'b0, mant_r} + {{N{1'b0}}, round_inc_c};
    assign frac_c      = rnd_sum_c[N] ? rnd_sum_c[N-1:1] : rnd_sum_c[N-2:0];
    assign exp_fin_c   = exp_sum_r + $signed({{(EW2-1){1'b0}}, rnd_sum_c[N]});

    fp_mult_shift_add #(
        .N (N)
    ) u_shift_add (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start_c),
        .a      ({1'b1, ma_c}),
        .b      ({1'b1, mb_c}),
        .prod   (mul_prod),
        .done_c (mul_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mul_start_c = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                if (special_c) begin
                    state_next = DONE;
                end else begin
                    state_next  = MULT;
                    mul_start_c = 1'b1;
                end
            end
            MULT: begin
                if (mul_done_c) begin
                    state_next = NORM;
                end
            end
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: each state updates only the registers it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            res_r       <= '0;
            sign_r      <= 1'b0;
            exp_sum_r   <= '0;
            mant_r      <= '0;
            g_r         <= 1'b0;
            r_r         <= 1'b0;
            s_r         <= 1'b0;
            nan_r       <= 1'b0;
            inf_r       <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            product_o   <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            nan_o       <= 1'b0;
            infinit_o   <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            done_o <= (state == DONE);
            busy_o <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_r <= a_i;
                        b_r <= b_i;
                    end
                end
                UNPACK: begin
                    sign_r    <= sign_c;
                    nan_r     <= 1'b0;
                    inf_r     <= 1'b0;
                    ovf_r     <= 1'b0;
                    unf_r     <= 1'b0;
                    exp_sum_r <= $signed({2'b00, ea_c}) + $signed({2'b00, eb_c}) - BIAS_S;
                    if (nan_case_c) begin
                        res_r <= QNAN;
                        nan_r <= 1'b1;
                    end else if (inf_case_c) begin
                        res_r <= {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        inf_r <= 1'b1;
                    end else begin
                        res_r <= {sign_c, {(W-1){1'b0}}};
                    end
                end
                NORM: begin
                    mant_r    <= norm_c[2*N-1 -: N];
                    g_r       <= norm_c[N-1];
                    r_r       <= norm_c[N-2];
                    s_r       <= |norm_c[N-3:0];
                    exp_sum_r <= exp_sum_r + $signed({{(EW2-1){1'b0}}, mul_prod[2*N-1]});
                end
                ROUND: begin
                    if (exp_fin_c >= EXP_TOP) begin
                        res_r <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        inf_r <= 1'b1;
                        ovf_r <= 1'b1;
                    end else if (exp_fin_c <= EXP_ZERO) begin
                        res_r <= {sign_r, {(W-1){1'b0}}};
                        unf_r <= 1'b1;
                    end else begin
                        res_r <= {sign_r, exp_fin_c[EXP_W-1:0], frac_c};
                    end
                end
                DONE: begin
                    product_o   <= res_r;
                    nan_o       <= nan_r;
                    infinit_o   <= inf_r;
                    overflow_o  <= ovf_r;
                    underflow_o <= unf_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
